// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//   Load/store sequencer between the RV32I execute stage and a word-wide data
//   RAM. Accepts one request at a time, checks alignment and funct3, issues a
//   word-aligned RAM access with byte strobes, waits for the acknowledge and
//   returns either extended load data or a store completion. req_ready stays
//   low for the whole access so the pipeline stalls.
//
//   Parameter
//     TIMEOUT_CYCLES : WAIT cycles without mem_ack before aborting with an
//                      error response (0 disables the timeout)
//
//   Ports
//     clk, reset            : rising-edge clock, synchronous active-high reset
//     req_valid/req_ready   : request handshake from the execute stage
//     req_we, funct3        : store/load select and access size/extension
//     addr, wdata           : byte address and right-justified store data
//     resp_valid, resp_err  : one-cycle completion pulse and its error flag
//     rdata                 : extended load result (0 for stores/errors)
//     mem_req/we/addr/wstrb/wdata : registered RAM access, held until ack
//     mem_ack, mem_rdata    : RAM completion and read word (same cycle)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic        req_illegal;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_word;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Request decode: legality, byte-lane strobes and lane-replicated store
  // data. Replicating the store data means the RAM can take the lane
  // selected by the strobes without any further shifting.
  always_comb begin
    req_illegal = 1'b0;
    lane_strb   = 4'b0000;
    lane_wdata  = wdata;
    case (funct3)
      3'b000: begin
        lane_strb  = 4'b0001 << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      3'b001: begin
        req_illegal = addr[0];
        lane_strb   = 4'b0011 << addr[1:0];
        lane_wdata  = {2{wdata[15:0]}};
      end
      3'b010: begin
        req_illegal = (addr[1:0] != 2'b00);
        lane_strb   = 4'b1111;
      end
      // Unsigned variants only exist for loads.
      3'b100: req_illegal = req_we;
      3'b101: req_illegal = req_we | addr[0];
      default: req_illegal = 1'b1;
    endcase
    if (!req_we) begin
      lane_strb = 4'b0000;
    end
  end

  // Load return path: the size and offset were captured at accept time,
  // because the execute-stage inputs are free to change during WAIT.
  always_comb begin
    load_word = mem_rdata >> {ld_off_q, 3'b000};
    case (ld_funct3_q)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'd0, load_word[7:0]};
      3'b101:  load_ext = {16'd0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // The counter holds the number of completed WAIT cycles, so the last
  // permitted WAIT cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign timeout_hit = (TIMEOUT_LIM != 32'd0) &&
                       (wait_cnt_q == (TIMEOUT_LIM - 32'd1));

  // Next-state and registered-output logic. Every output is a flop, so the
  // values below are what appears on the ports one cycle later.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    ld_funct3_d  = ld_funct3_q;
    ld_off_d     = ld_off_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            // Rejected without touching the RAM.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = 32'd0;
          end else begin
            state_d     = ST_WAIT;
            wait_cnt_d  = 32'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wstrb_d = lane_strb;
            mem_wdata_d = lane_wdata;
            ld_funct3_d = funct3;
            ld_off_d    = addr[1:0];
          end
        end
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        // An ack arriving on the timeout edge still completes normally.
        if (mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          rdata_d      = mem_we_q ? 32'd0 : load_ext;
        end else if (timeout_hit) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          rdata_d      = 32'd0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset; a reset in the middle
  // of an access simply drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      mem_wdata_q  <= 32'd0;
      ld_funct3_q  <= 3'd0;
      ld_off_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_off_q     <= ld_off_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl with a short timeout. Directed cases cover
//   the documented examples, then random transactions are checked against a
//   behavioural model of the load/store rules.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int testsRun;
  int testsFailed;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference rules for legality of a request.
  function automatic bit modelLegal(input bit we, input int f3, input int off);
    case (f3)
      0: return 1'b1;
      1: return (off % 2) == 0;
      2: return off == 0;
      4: return !we;
      5: return !we && ((off % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Reference load result: pick the addressed bytes, then extend.
  function automatic logic [31:0] modelLoad(input int f3, input int off,
                                            input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word / (32'd1 << (8 * off));
    case (f3)
      0: begin v = sh % 256;   if (v >= 128)   v = v - 32'd256;   end
      1: begin v = sh % 65536; if (v >= 32768) v = v - 32'd65536; end
      4: v = sh % 256;
      5: v = sh % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  // One complete transaction: present the request in IDLE, supply mem_ack
  // in WAIT cycle ackDelay+1, and check every cycle up to the response.
  task automatic applyStimulus(input bit we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rword, input int ackDelay);
    int          off;
    bit          legal;
    bit          timedOut;
    int          ackCycle;
    int          respCycle;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    bit          expErr;

    off      = int'(a % 4);
    legal    = modelLegal(we, int'(f3), off);
    ackCycle = ackDelay + 1;
    timedOut = ackCycle > TO;
    expStrb  = 4'd0;
    expWdata = wd;
    if (we) begin
      case (f3)
        3'd0: begin expStrb = 4'(1 << off); expWdata = (wd % 256) * 32'h0101_0101; end
        3'd1: begin expStrb = 4'(3 << off); expWdata = (wd % 65536) * 32'h0001_0001; end
        default: expStrb = 4'hF;
      endcase
    end
    if (!legal)        respCycle = 1;
    else if (timedOut) respCycle = TO + 1;
    else               respCycle = ackCycle + 1;
    expErr   = !legal || timedOut;
    expRdata = (expErr || we) ? 32'd0 : modelLoad(int'(f3), off, rword);

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    for (int cyc = 1; cyc <= respCycle; cyc++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (cyc < respCycle) begin
        checkOutput("resp_valid_busy", 32'(resp_valid), 32'd0);
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        checkOutput("mem_req_wait", 32'(mem_req), 32'd1);
        checkOutput("mem_addr", mem_addr, {a[31:2], 2'b00});
        checkOutput("mem_we", 32'(mem_we), 32'(we));
        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(expStrb));
        if (we) checkOutput("mem_wdata", mem_wdata, expWdata);
        // Busy-time request inputs must be ignored.
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        funct3    = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        if (cyc == ackCycle) begin
          mem_ack   = 1'b1;
          mem_rdata = rword;
        end
      end else begin
        req_valid = 1'b0;
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_err", 32'(resp_err), 32'(expErr));
        checkOutput("rdata", rdata, expRdata);
        checkOutput("mem_req_resp", 32'(mem_req), 32'd0);
        checkOutput("req_ready_resp", 32'(req_ready), 32'd0);
      end
    end

    @(negedge clk);
    checkOutput("resp_valid_after", 32'(resp_valid), 32'd0);
    checkOutput("req_ready_after", 32'(req_ready), 32'd1);
    checkOutput("mem_req_after", 32'(mem_req), 32'd0);

    // Idle gap with stray acks, which must not provoke anything.
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    funct3      = 3'd0;
    addr        = 32'd0;
    wdata       = 32'd0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'd0;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'hBEEF_1234, 1);
    applyStimulus(1'b0, 3'b001, 32'h0000_0202, 32'd0, 32'hBEEF_1234, 2);
    applyStimulus(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'd0, 0);
    applyStimulus(1'b1, 3'b001, 32'h0000_0401, 32'h1234_5678, 32'd0, 0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0402, 32'd0, 32'd0, 0);
    applyStimulus(1'b1, 3'b100, 32'h0000_0500, 32'h0000_0011, 32'd0, 0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'd0, 32'hCAFE_F00D, 10);
    applyStimulus(1'b0, 3'b010, 32'h0000_0700, 32'd0, 32'h1357_9BDF, TO - 1);
    applyStimulus(1'b1, 3'b010, 32'h0000_0800, 32'hDEAD_BEEF, 32'd0, TO);

    // Reset in the middle of an access, followed by a late acknowledge.
    req_valid = 1'b1;
    req_we    = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0900;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("rst_mid");
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checkResetValues("late_ack");
    @(negedge clk);
    checkResetValues("late_ack2");

    // Randomized transactions.
    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic [2:0]  f3;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      f3  = (sel < 8) ? 3'(sel) : ((sel == 8) ? 3'b000 : 3'b010);
      a   = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      applyStimulus(1'($urandom), f3, a, $urandom, $urandom,
                    int'($urandom_range(0, TO + 2)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
